// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, canonical NOP, fetch FSM
// states and the IF/ID pipeline register layout used by fetch and decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > stall hold > consume-clear,
// so the decoder sees NOP whenever the entry is not valid.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   load,
  input  logic   stall,
  input  if_id_t load_data,
  output if_id_t entry_reg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_reg.valid    <= 1'b0;
      entry_reg.instr    <= NOP_INSTR;
      entry_reg.pc       <= '0;
      entry_reg.pc_plus4 <= '0;
    end else if (flush) begin
      entry_reg.valid <= 1'b0;
      entry_reg.instr <= NOP_INSTR;
    end else if (load) begin
      entry_reg <= load_data;
    end else if (!(entry_reg.valid && stall)) begin
      // Consumed (or already empty): park a NOP; PC fields are don't-care.
      entry_reg.valid <= 1'b0;
      entry_reg.instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem request FSM and the
// IF/ID register, with decode stalls and execute redirects (wrong-path kill).
module fetch_stage
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
)
(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4
);
  import riscv_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic            kill_reg, kill_next;
  logic [XLEN-1:0] pc_reg, pend_pc_reg;
  logic [XLEN-1:0] redirect_target;
  logic            req_fire, rsp_fire, slot_free, live_rsp;
  if_id_t          if_id, load_data;

  assign slot_free       = !if_id.valid || !id_stall;
  assign imem_rsp_ready  = kill_reg || slot_free;
  assign rsp_fire        = imem_rsp_valid && imem_rsp_ready;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  // A new request may overlap the cycle the previous response lands,
  // which sustains one fetch per cycle against a zero-wait memory.
  assign imem_req_valid = rst_n && !redirect_valid &&
                          ((state_reg == IDLE) ||
                           ((state_reg == PEND) && rsp_fire && !kill_reg));
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign live_rsp = rsp_fire && (state_reg == PEND) && !kill_reg && !redirect_valid;

  always_comb begin
    state_next = state_reg;
    if (req_fire)
      state_next = PEND;
    else if (rsp_fire)
      state_next = IDLE;
  end

  // An in-flight request at redirect time belongs to the wrong path.
  always_comb begin
    kill_next = kill_reg && !rsp_fire;
    if (redirect_valid)
      kill_next = (state_reg == PEND) && !rsp_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      pend_pc_reg <= '0;
      state_reg   <= IDLE;
      kill_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
      if (redirect_valid)
        pc_reg <= redirect_target;
      else if (req_fire)
        pc_reg <= pc_reg + XLEN'(4);
      if (req_fire)
        pend_pc_reg <= pc_reg;
    end
  end

  assign load_data = {1'b1, imem_rsp_data, pend_pc_reg, pend_pc_reg + XLEN'(4)};

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .load      (live_rsp),
    .stall     (id_stall),
    .load_data (load_data),
    .entry_reg (if_id)
  );

  assign if_id_valid    = if_id.valid;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus4 = if_id.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based memory with random
// latency plus an in-order expected instruction-stream model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready;
  logic        redirect_valid, id_stall, if_id_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;

  logic        w_rst_n = 1'b0, w_rsp_valid = 1'b0;
  logic        w_req_valid, w_rsp_ready, w_if_id_valid;
  logic [31:0] w_req_addr, w_if_id_instr, w_if_id_pc, w_if_id_pc_plus4;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_ready(w_rsp_ready),
    .imem_rsp_data(32'hCAFE_0013),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_stall(1'b0),
    .if_id_valid(w_if_id_valid), .if_id_instr(w_if_id_instr),
    .if_id_pc(w_if_id_pc), .if_id_pc_plus4(w_if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          wait_cnt;
  } mreq_t;

  mreq_t       mq[$];
  int          lat_min = 1, lat_max = 1;
  logic [31:0] exp_req, exp_id;
  int          checks = 0, errors = 0;
  logic        s_req_fire, s_rsp_fire, s_redir, s_consume;
  logic [31:0] s_rpc, s_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_req = 32'h0;
    exp_id  = 32'h0;
  endtask

  // Called on the falling edge: applies inputs and lets outputs settle.
  task automatic drive(input logic stall, input logic redir,
                       input logic [31:0] rpc, input logic rdy);
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mq.size() > 0) begin
      if (mq[0].wait_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(mq[0].addr);
      end
    end
    #1;
  endtask

  // Stream checks for the current cycle, then advance one clock and the model.
  task automatic step();
    int lat;
    checks++;
    if (!if_id_valid && if_id_instr !== NOP) begin
      errors++;
      $display("FAIL nop_when_invalid: instr=%h required %h", if_id_instr, NOP);
    end
    if (if_id_valid) begin
      checks++;
      if (if_id_pc_plus4 !== if_id_pc + 32'd4) begin
        errors++;
        $display("FAIL pc_plus4: got %h required %h", if_id_pc_plus4, if_id_pc + 32'd4);
      end
    end
    if (redirect_valid) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_in_redirect: req_valid=%b required 0", imem_req_valid);
      end
    end
    if (imem_req_valid === 1'b1) begin
      checks++;
      if (imem_req_addr !== exp_req) begin
        errors++;
        $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_req);
      end
    end
    s_consume = if_id_valid && !id_stall && !redirect_valid;
    if (s_consume) begin
      checks++;
      if (if_id_pc !== exp_id || if_id_instr !== memf(exp_id)) begin
        errors++;
        $display("FAIL issue_stream: pc=%h instr=%h required pc=%h instr=%h",
                 if_id_pc, if_id_instr, exp_id, memf(exp_id));
      end else begin
        $display("issue pc=%h instr=%h", if_id_pc, if_id_instr);
      end
    end
    s_req_fire = imem_req_valid && imem_req_ready;
    s_rsp_fire = imem_rsp_valid && imem_rsp_ready;
    s_redir    = redirect_valid;
    s_rpc      = redirect_pc;
    s_addr     = imem_req_addr;
    @(posedge clk);
    if (s_redir) begin
      exp_req = s_rpc & ~32'd3;
      exp_id  = s_rpc & ~32'd3;
      $display("redirect target=%h", exp_req);
    end else begin
      if (s_req_fire) exp_req = exp_req + 32'd4;
      if (s_consume)  exp_id  = exp_id + 32'd4;
    end
    if (s_rsp_fire && mq.size() > 0) void'(mq.pop_front());
    foreach (mq[i]) if (mq[i].wait_cnt > 0) mq[i].wait_cnt = mq[i].wait_cnt - 1;
    if (s_req_fire) begin
      lat = $urandom_range(lat_max, lat_min);
      mq.push_back('{addr: s_addr, wait_cnt: lat - 1});
    end
    checks++;
    if (mq.size() > 1) begin
      errors++;
      $display("FAIL outstanding: %0d requests in flight, required at most 1", mq.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
        if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL %s: req_v=%b v=%b instr=%h pc=%h pc4=%h required 0 0 %h 0 0",
               tag, imem_req_valid, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, NOP);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (k < 3) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
          errors++;
          $display("FAIL zero_wait_req: k=%0d v=%b addr=%h required 1 %h",
                   k, imem_req_valid, imem_req_addr, 32'(4 * k));
        end
      end
      checks++;
      if (k >= 2 && (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (k - 2)))) begin
        errors++;
        $display("FAIL zero_wait_ifid: k=%0d v=%b pc=%h required 1 %h",
                 k, if_id_valid, if_id_pc, 32'(4 * (k - 2)));
      end else if (k < 2 && if_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_wait_latency: k=%0d v=%b required 0", k, if_id_valid);
      end
      step();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || imem_rsp_ready !== 1'b0 ||
          imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: v=%b pc=%h rsp_rdy=%b req_v=%b required 1 00000008 0 0",
                 if_id_valid, if_id_pc, imem_rsp_ready, imem_req_valid);
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (imem_rsp_ready !== 1'b1 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: rsp_rdy=%b req_v=%b required 1 1", imem_rsp_ready, imem_req_valid);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC) begin
      errors++;
      $display("FAIL stall_capture: v=%b pc=%h required 1 0000000c", if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_redirect_rsp();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (imem_rsp_valid && mq.size() > 0 && mq[0].addr == 32'h10) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirect_rsp_setup: response for 00000010 not seen within bound");
    end
    drive(1'b0, 1'b1, 32'h103, 1'b1);
    checks++;
    if (imem_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL redirect_rsp_ready: rsp_rdy=%b required 1", imem_rsp_ready);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_rsp_flush: v=%b instr=%h req_v=%b addr=%h required 0 %h 1 00000100",
               if_id_valid, if_id_instr, imem_req_valid, imem_req_addr, NOP);
    end
    step();
  endtask

  task automatic test_redirect_kill();
    bit found = 0;
    lat_min = 4;
    lat_max = 4;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (mq.size() == 1 && !imem_rsp_valid) found = 1;
      else step();
    end
    drive(1'b0, 1'b1, 32'h200, 1'b1);
    step();
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (imem_req_valid === 1'b1) begin
        found = 1;
        checks++;
        if (imem_req_addr !== 32'h200 || mq.size() != 0) begin
          errors++;
          $display("FAIL kill_resume: addr=%h inflight=%0d required 00000200 0",
                   imem_req_addr, mq.size());
        end
      end
      checks++;
      if (if_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL kill_wrong_path: if_id_valid=%b pc=%h required 0", if_id_valid, if_id_pc);
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL kill_timeout: no request after killed response");
    end
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic test_backpressure();
    bit found = 0;
    drive(1'b0, 1'b1, 32'h20, 1'b0);
    step();
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      if (imem_req_valid === 1'b1) found = 1;
      else step();
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20) begin
        errors++;
        $display("FAIL backpressure_hold: i=%0d v=%b addr=%h required 1 00000020",
                 i, imem_req_valid, imem_req_addr);
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (imem_req_valid === 1'b1) begin
        found = 1;
        checks++;
        if (imem_req_addr !== 32'h24) begin
          errors++;
          $display("FAIL backpressure_next: addr=%h required 00000024", imem_req_addr);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, $urandom,
            $urandom_range(99, 0) < 70);
      step();
    end
    lat_min = 1;
    lat_max = 1;
  endtask

  task automatic test_reset_mid_pend();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (if_id_valid === 1'b1 && mq.size() == 1) found = 1;
      else step();
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL restart_req: k=%0d v=%b addr=%h required 1 %h",
                 k, imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      step();
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    w_rst_n = 1'b1;
    #1;
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first: v=%b addr=%h required 1 fffffffc", w_req_valid, w_req_addr);
    end
    @(negedge clk);
    w_rsp_valid = 1'b1;
    #1;
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_second: v=%b addr=%h required 1 00000000", w_req_valid, w_req_addr);
    end
    @(negedge clk);
    w_rsp_valid = 1'b0;
    #1;
    checks++;
    if (w_if_id_valid !== 1'b1 || w_if_id_pc !== 32'hFFFF_FFFC || w_if_id_pc_plus4 !== 32'h0 ||
        w_if_id_instr !== 32'hCAFE_0013) begin
      errors++;
      $display("FAIL wrap_ifid: v=%b pc=%h pc4=%h instr=%h required 1 fffffffc 00000000 cafe0013",
               w_if_id_valid, w_if_id_pc, w_if_id_pc_plus4, w_if_id_instr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_rsp();
    test_redirect_kill();
    test_backpressure();
    test_random();
    test_reset_mid_pend();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
